// File: rtl/harmonic_synth_if.sv
// Request/response bundle between the note player and the harmonic voice generator.
// Handshake: generate_next_sample is a one-cycle request taken only when the generator is idle and
// play_enable is high; each accepted request yields exactly one sample_ready pulse with harmonic_out valid.
interface harmonic_synth_if #(
  parameter int NUM_HARM = 4,
  parameter int WEIGHT_W = 3,
  parameter int OUT_W    = 18
);
  logic                         play_enable;
  logic                         generate_next_sample;
  logic [19:0]                  step_size;
  logic [NUM_HARM*WEIGHT_W-1:0] weights;
  logic                         mode;
  logic signed [OUT_W-1:0]      harmonic_out;
  logic                         sample_ready;
  logic                         busy;
  logic [1:0]                   fsm_state;

  modport master (
    output play_enable, generate_next_sample, step_size, weights, mode,
    input  harmonic_out, sample_ready, busy, fsm_state
  );

  modport slave (
    input  play_enable, generate_next_sample, step_size, weights, mode,
    output harmonic_out, sample_ready, busy, fsm_state
  );
endinterface

// File: rtl/harmonic_synth.sv
// Additive harmonic voice: NUM_HARM phase accumulators share one registered sine ROM,
// one partial per cycle, weighted and summed into a saturated sample.
module harmonic_synth #(
  parameter int NUM_HARM = 4,
  parameter int WEIGHT_W = 3,
  parameter int OUT_W    = 18
) (
  input  logic             clk,
  input  logic             reset,
  harmonic_synth_if.slave  bus
);
  localparam int IDX_W  = (NUM_HARM > 1) ? $clog2(NUM_HARM) : 1;
  localparam int ACC_W  = 16 + WEIGHT_W + $clog2(NUM_HARM) + 1;
  localparam int PROD_W = 17 + WEIGHT_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_HARM - 1);
  localparam longint OUT_MAX = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;
  localparam longint OUT_MIN = -(64'sd1 <<< (OUT_W - 1));
  // Odd polynomial for sin(pi/2 * t), Q16 coefficients chosen to sum to exactly 1.0
  localparam longint SIN_A = 64'sd102917;
  localparam longint SIN_B = -64'sd42120;
  localparam longint SIN_C = 64'sd4739;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]                   state;
  logic [19:0]                  phase [NUM_HARM];
  logic [19:0]                  step_q;
  logic [19:0]                  inc_run;
  logic [NUM_HARM*WEIGHT_W-1:0] weights_q;
  logic                         mode_q;
  logic [IDX_W-1:0]             idx;
  logic [9:0]                   rom_addr;
  logic [WEIGHT_W-1:0]          cur_weight;
  logic signed [15:0]           rom_data;
  logic                         rd_valid;
  logic [WEIGHT_W-1:0]          rd_weight;
  logic signed [PROD_W-1:0]     prod;
  logic signed [ACC_W-1:0]      contrib;
  logic signed [ACC_W-1:0]      acc;
  logic signed [OUT_W-1:0]      sat_val;
  logic signed [OUT_W-1:0]      out_q;
  logic                         ready_q;

  function automatic logic signed [15:0] sine_lut(input logic [9:0] a);
    longint u;
    longint t;
    u = {56'd0, a[7:0]};
    if (a[8]) u = 64'sd256 - u;
    t = ((SIN_A * u) <<< 32) + ((SIN_B * u * u * u) <<< 16) + (SIN_C * u * u * u * u * u);
    t = t >>> 24;
    t = (t * 64'sd32767) >>> 32;
    return a[9] ? -16'(t) : 16'(t);
  endfunction

  always_comb begin
    rom_addr   = '0;
    cur_weight = '0;
    for (int k = 0; k < NUM_HARM; k++) begin
      if (idx == IDX_W'(k)) begin
        rom_addr   = phase[k][19:10];
        cur_weight = weights_q[k*WEIGHT_W +: WEIGHT_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    rom_data <= sine_lut(rom_addr);
  end

  // Arithmetic shift floors toward negative infinity, matching the gain definition
  always_comb begin
    prod    = PROD_W'(rom_data) * PROD_W'($signed({1'b0, rd_weight}));
    contrib = ACC_W'(prod >>> WEIGHT_W);
  end

  always_comb begin
    sat_val = OUT_W'(longint'(acc));
    if (longint'(acc) > OUT_MAX) sat_val = OUT_W'(OUT_MAX);
    else if (longint'(acc) < OUT_MIN) sat_val = OUT_W'(OUT_MIN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      for (int k = 0; k < NUM_HARM; k++) phase[k] <= '0;
      step_q    <= '0;
      inc_run   <= '0;
      weights_q <= '0;
      mode_q    <= 1'b0;
      idx       <= '0;
      rd_valid  <= 1'b0;
      rd_weight <= '0;
      acc       <= '0;
      out_q     <= '0;
      ready_q   <= 1'b0;
    end else begin
      ready_q   <= 1'b0;
      rd_valid  <= (state == RUN);
      rd_weight <= cur_weight;
      if (rd_valid) acc <= acc + contrib;
      case (state)
        IDLE: begin
          if (bus.generate_next_sample && bus.play_enable) begin
            step_q    <= bus.step_size;
            inc_run   <= bus.step_size;
            weights_q <= bus.weights;
            mode_q    <= bus.mode;
            idx       <= '0;
            acc       <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < NUM_HARM; k++) begin
            if (idx == IDX_W'(k)) phase[k] <= phase[k] + inc_run;
          end
          // Running increment: step*k by repeated add, or step>>(k-1) by repeated halving
          inc_run <= mode_q ? (inc_run >> 1) : (inc_run + step_q);
          if (idx == LAST) state <= DRAIN;
          else             idx   <= idx + 1'b1;
        end
        DRAIN: state <= DONE;
        default: begin
          out_q   <= sat_val;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.harmonic_out = out_q;
  assign bus.sample_ready = ready_q;
  assign bus.busy         = (state != IDLE);
  assign bus.fsm_state    = state;
endmodule

// File: tb/tb_harmonic_synth.sv
// Directed bench for harmonic_synth: default, 8-partial and 1-partial/15-bit instances
// with hand-computed sample values, latency and busy windows.
module tb_harmonic_synth;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic signed [31:0] exp_q[$];

  always #5 clk = ~clk;

  harmonic_synth_if #(.NUM_HARM(4), .WEIGHT_W(3), .OUT_W(18)) bus4 ();
  harmonic_synth_if #(.NUM_HARM(8), .WEIGHT_W(3), .OUT_W(18)) bus8 ();
  harmonic_synth_if #(.NUM_HARM(1), .WEIGHT_W(3), .OUT_W(15)) bus1 ();

  harmonic_synth #(.NUM_HARM(4), .WEIGHT_W(3), .OUT_W(18)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
  harmonic_synth #(.NUM_HARM(8), .WEIGHT_W(3), .OUT_W(18)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
  harmonic_synth #(.NUM_HARM(1), .WEIGHT_W(3), .OUT_W(15)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_req(input int which, input logic v);
    case (which)
      4:       bus4.generate_next_sample = v;
      8:       bus8.generate_next_sample = v;
      default: bus1.generate_next_sample = v;
    endcase
  endtask

  task automatic peek(input int which, output logic rdy, output logic bsy, output longint val);
    case (which)
      4:       begin rdy = bus4.sample_ready; bsy = bus4.busy; val = longint'(bus4.harmonic_out); end
      8:       begin rdy = bus8.sample_ready; bsy = bus8.busy; val = longint'(bus8.harmonic_out); end
      default: begin rdy = bus1.sample_ready; bsy = bus1.busy; val = longint'(bus1.harmonic_out); end
    endcase
  endtask

  // One request: latency, busy window, optional sample value and single-cycle pulse
  task automatic request(input int which, input string tag, input logic signed [31:0] exp,
                         input bit check_val, input int exp_lat);
    int lat;
    int busy_cnt;
    logic rdy;
    logic bsy;
    longint val;
    logic signed [31:0] e;
    exp_q.push_back(exp);
    set_req(which, 1'b1);
    tick();
    set_req(which, 1'b0);
    lat = 0;
    busy_cnt = 0;
    peek(which, rdy, bsy, val);
    while (!rdy && lat < 40) begin
      busy_cnt += int'(bsy);
      tick();
      lat++;
      peek(which, rdy, bsy, val);
    end
    e = exp_q.pop_front();
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_cycles"}, busy_cnt, exp_lat);
    check({tag, "_busy_at_ready"}, bsy, 0);
    if (check_val) check({tag, "_value"}, val, e);
    tick();
    peek(which, rdy, bsy, val);
    check({tag, "_pulse_width"}, rdy, 0);
  endtask

  initial begin
    int pulses;
    int busy_seen;
    int lat;
    longint last;

    bus4.play_enable = 1'b1; bus4.generate_next_sample = 1'b0; bus4.mode = 1'b0;
    bus4.step_size = 20'(256 << 10); bus4.weights = 12'h924;
    bus8.play_enable = 1'b1; bus8.generate_next_sample = 1'b0; bus8.mode = 1'b0;
    bus8.step_size = 20'd0; bus8.weights = 24'hFFFFFF;
    bus1.play_enable = 1'b1; bus1.generate_next_sample = 1'b0; bus1.mode = 1'b0;
    bus1.step_size = 20'(256 << 10); bus1.weights = 3'd7;

    repeat (3) tick();
    check("reset_out", bus4.harmonic_out, 0);
    check("reset_ready", bus4.sample_ready, 0);
    check("reset_busy", bus4.busy, 0);
    check("reset_state", bus4.fsm_state, 0);
    reset = 1'b0;
    tick();

    // Overtones, weight 4: first sample from phase 0, second reads 256/512/768/0
    request(4, "ot_first", 0, 1'b1, 6);
    request(4, "ot_second", -1, 1'b1, 6);

    // Request pulsed while busy is dropped; this run reads 512/0/512/0
    set_req(4, 1'b1); tick(); set_req(4, 1'b0); tick(); tick();
    set_req(4, 1'b1); tick(); set_req(4, 1'b0);
    pulses = 0;
    last = 99999;
    for (int i = 0; i < 20; i++) begin
      if (bus4.sample_ready) begin
        pulses++;
        last = longint'(bus4.harmonic_out);
      end
      tick();
    end
    check("busy_req_pulses", pulses, 1);
    check("busy_req_value", last, 0);

    // Inputs changed mid-run are not seen; reads 768/512/256/0
    set_req(4, 1'b1); tick(); set_req(4, 1'b0);
    bus4.weights = '0; bus4.step_size = '0; bus4.mode = 1'b1;
    lat = 0;
    while (!bus4.sample_ready && lat < 40) begin tick(); lat++; end
    check("latched_cfg_ready", bus4.sample_ready, 1);
    check("latched_cfg_value", bus4.harmonic_out, -1);
    bus4.weights = 12'h924; bus4.step_size = 20'(256 << 10); bus4.mode = 1'b0;
    tick();

    // play_enable low: held request ignored, output and phases hold
    bus4.play_enable = 1'b0;
    bus4.generate_next_sample = 1'b1;
    pulses = 0;
    busy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      pulses += int'(bus4.sample_ready);
      busy_seen += int'(bus4.busy);
    end
    bus4.generate_next_sample = 1'b0;
    check("paused_pulses", pulses, 0);
    check("paused_busy", busy_seen, 0);
    check("paused_hold", bus4.harmonic_out, -1);
    bus4.play_enable = 1'b1;
    tick();
    request(4, "resume_a", 0, 1'b1, 6);
    request(4, "resume_b", -1, 1'b1, 6);

    // Asynchronous reset in the middle of a run
    set_req(4, 1'b1); tick(); set_req(4, 1'b0); tick();
    reset = 1'b1;
    #1;
    check("async_rst_out", bus4.harmonic_out, 0);
    check("async_rst_ready", bus4.sample_ready, 0);
    check("async_rst_busy", bus4.busy, 0);
    check("async_rst_state", bus4.fsm_state, 0);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      pulses += int'(bus4.sample_ready);
    end
    check("async_rst_no_pulse", pulses, 0);
    request(4, "post_rst_a", 0, 1'b1, 6);
    request(4, "post_rst_b", -1, 1'b1, 6);

    // Undertones: only partial 3 (weight 7), inc_3 = 128<<10
    reset = 1'b1; tick(); reset = 1'b0; tick();
    bus4.mode = 1'b1; bus4.step_size = 20'(512 << 10); bus4.weights = 12'h1C0;
    request(4, "ut_first", 0, 1'b1, 6);
    request(4, "ut_second", 0, 1'b0, 6);
    request(4, "ut_third", 28671, 1'b1, 6);

    request(8, "h8", 0, 1'b1, 10);

    // Single partial, 15-bit output: saturates at both rails
    request(1, "h1_a", 0, 1'b1, 3);
    request(1, "h1_b", 16383, 1'b1, 3);
    request(1, "h1_c", 0, 1'b1, 3);
    request(1, "h1_d", -16384, 1'b1, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/harmonic_synth.md
Name: harmonic_synth

Overview:
Parametrised additive-harmonic voice generator for the music-player note path. Produces one NUM_HARM-partial sample per request using a single time-multiplexed sine ROM. Each partial has its own phase accumulator, a runtime weight, and a selectable overtone or undertone series. It sits between the note player's step_size/sample-request logic and the codec/mixer path, and replaces the fixed 3-partial, fixed-weight generator.

Parameters:
NUM_HARM, 4, number of partials, 1..8; partial k = 1..NUM_HARM
WEIGHT_W, 3, bits per partial weight; gain = weight / 2^WEIGHT_W
OUT_W, 18, signed output width; the sum saturates to this width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
play_enable  in  1  high = requests are accepted; low = requests ignored, phases hold
generate_next_sample  in  1  one-cycle sample request
step_size  in  20  fundamental phase increment, unsigned 10.10 fixed point
weights  in  NUM_HARM*WEIGHT_W  unsigned weight per partial; partial k uses slice [(k-1)*WEIGHT_W +: WEIGHT_W]
mode  in  1  0 = overtones (inc_k = step_size*k), 1 = undertones (inc_k = step_size >> (k-1))
harmonic_out  out  OUT_W  signed, saturated sum; registered
sample_ready  out  1  one-cycle pulse; harmonic_out is valid from the same cycle
busy  out  1  high while a sample is being computed

Behaviour:
- Reset, asynchronous and active-high:
  - all phase accumulators are 0;
  - harmonic_out is 0, sample_ready is 0, busy is 0;
  - FSM is in IDLE;
  - an in-flight computation is discarded and no sample_ready is produced for it.
- Phase and increment rules:
  - Each phase_k is 20 bits and wraps modulo 2^20.
  - ROM address is phase_k[19:10], 10 bits, one full cycle.
  - inc_k is truncated to 20 bits. The overtone product may be formed with a running adder; it need not be a multiplier.
- ROM: 1024-entry, 16-bit signed full-wave sine, one-cycle registered read. Address 256 reads +32767, address 768 reads -32767.
- FSM states IDLE, RUN, DRAIN, DONE:
  - IDLE, request accepted: when generate_next_sample && play_enable is sampled high, latch step_size, weights and mode; clear the accumulator; idx = 0; go to RUN.
  - IDLE, no request: a request while play_enable is low is dropped. No state changes and harmonic_out holds.
  - RUN: one partial per cycle. Issue ROM address from phase_idx, then write phase_idx += inc_idx. The old phase is used for the read, so the first sample after reset reads phase 0. When idx = NUM_HARM-1, go to DRAIN.
  - Accumulate: ROM data returns one cycle after issue. acc += (data * weight) >>> WEIGHT_W, an arithmetic shift that floors toward negative infinity.
  - Accumulator width: 16 + WEIGHT_W + clog2(NUM_HARM) + 1 bits, so no internal overflow.
  - DRAIN: absorb the last ROM return, then go to DONE.
  - DONE: harmonic_out <= sat(acc), clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. sample_ready = 1 for exactly one cycle. Go to IDLE.
- Latency: sample_ready is high exactly NUM_HARM+2 cycles after the request is sampled.
- busy is high in RUN, DRAIN and DONE.
- Requests while busy are ignored, not queued.
- play_enable falling mid-computation does not abort; the sample completes.
- Weights, step_size and mode changing mid-computation have no effect, because they are latched at accept.
- A request coincident with DONE is ignored; the next request is accepted from IDLE.
- A zero-weight partial still advances its phase.
- harmonic_out holds its value between samples.

Test Plan:
1. Defaults. Assert reset mid-RUN -> harmonic_out = 0, sample_ready = 0, busy = 0 immediately (asynchronous), with no stray pulse. First request after release -> harmonic_out = 0 (all phases 0).
2. Defaults, overtone mode, step_size = 256<<10, all weights = 4, two requests. First -> 0. Second reads addresses 256/512/768/0, giving 16383 + 0 - 16384 + 0 -> harmonic_out = -1.
3. Latency. NUM_HARM = 4: sample_ready exactly 6 cycles after the request. NUM_HARM = 8: exactly 10 cycles. busy spans exactly the RUN, DRAIN and DONE cycles. A request pulsed while busy -> no extra sample_ready.
4. NUM_HARM = 1, OUT_W = 15, weight 7, step_size = 256<<10, four requests -> harmonic_out sequence 0, 16383 (saturated from 28671), 0, -16384 (saturated from -28672).
5. Undertone mode, NUM_HARM = 4, step_size = 512<<10, only weight_3 = 7 (others 0). inc_3 = 128<<10, so the 3rd request reads address 256 -> 28671.
6. play_enable low with requests for 10 cycles -> no sample_ready and harmonic_out unchanged. Re-enable and request -> the phase sequence continues from where it was paused.
